// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter sequencing and instruction fetch control
//
// Purpose:
//   Holds the PC and issues one fetch request per instruction. When memory
//   acknowledges, it presents the instruction for one EXEC cycle. It then
//   selects the next PC from halt > jump > branch > pc+4.
//   State sequence: BOOT -> FETCH -> EXEC -> FETCH ...; EXEC -> HALTED on halt.
//   HALTED is terminal until reset.
//
// Optional feature:
//   PC_ALIGN_CHECK_EN - when defined, a jump or branch target whose bits[1:0]
//   are non-zero redirects the PC to EXC_VECTOR and sets the sticky addr_err
//   flag. When undefined, targets load verbatim and addr_err is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   imem_req       fetch request to instruction memory (high throughout FETCH)
//   imem_addr      fetch address, always equal to pc
//   imem_ack       memory returns the instruction this cycle (FETCH only)
//   instr_valid    one-cycle pulse in EXEC: instruction at pc is ready
//   branch_taken   EXEC only: take branch_target
//   branch_target  branch destination
//   jump           EXEC only: take jump_target (wins over branch_taken)
//   jump_target    jump destination
//   halt           EXEC only: stop fetching (wins over everything)
//   pc             current PC
//   pc_plus4       pc + 4 modulo 2^PC_WIDTH, combinational
//   halted         high while in HALTED
//   addr_err       sticky misaligned-target flag

module pc_fetch_ctrl #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]    EXC_VECTOR   = PC_WIDTH'(32'h0000_0180)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    output logic                instr_valid,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                halted,
    output logic                addr_err
);

    // The exception vector must itself be a legal fetch address, and the
    // low two bits are needed for the alignment test.
    if (PC_WIDTH < 3) begin : g_bad_width
        $error("PC_WIDTH must be at least 3");
    end
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_exc
        $error("EXC_VECTOR must be word aligned");
    end

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  imem_req_q;
    logic                  instr_valid_q;
    logic                  halted_q;

    logic [PC_WIDTH-1:0]   pc_plus4_d;
    logic [PC_WIDTH-1:0]   pc_d;
    logic [PC_WIDTH-1:0]   target_d;
    logic                  take_target_d;

    // Sequential successor; wraps silently at the top of the address space.
    assign pc_plus4_d = pc_q + PC_WIDTH'(4);

    // Next-PC selection, evaluated every cycle but only consumed in EXEC.
    // Halt is handled in the FSM because it freezes the PC instead of
    // choosing a new value.
    always_comb begin
        take_target_d = 1'b0;
        target_d      = branch_target;
        if (jump) begin
            take_target_d = 1'b1;
            target_d      = jump_target;
        end else if (branch_taken) begin
            take_target_d = 1'b1;
            target_d      = branch_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic addr_err_q;
    logic misaligned_d;

    // Only redirected targets are checked; pc+4 from an aligned PC stays aligned.
    assign misaligned_d = take_target_d && (target_d[1:0] != 2'b00);

    always_comb begin
        pc_d = take_target_d ? target_d : pc_plus4_d;
        if (misaligned_d) begin
            pc_d = EXC_VECTOR;
        end
    end

    assign addr_err = addr_err_q;
`else
    always_comb begin
        pc_d = take_target_d ? target_d : pc_plus4_d;
    end

    assign addr_err = 1'b0;
`endif

    // All outputs are registered and move together with the state. The
    // asynchronous reset therefore drops imem_req in the same cycle that
    // reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            addr_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end

                ST_FETCH: begin
                    // Address is held on pc_q, so it stays stable across wait states.
                    if (imem_ack) begin
                        state_q       <= ST_EXEC;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    instr_valid_q <= 1'b0;
                    if (halt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                        pc_q       <= pc_d;
`ifdef PC_ALIGN_CHECK_EN
                        if (misaligned_d) begin
                            addr_err_q <= 1'b1;
                        end
`endif
                    end
                end

                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end

                default: begin
                    state_q       <= ST_BOOT;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard testbench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc  = '0;
    logic        m_err = 1'b0;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic junk_controls();
        jump          = 1'($urandom);
        branch_taken  = 1'($urandom);
        halt          = 1'($urandom);
        jump_target   = $urandom;
        branch_target = $urandom;
    endtask

    task automatic clear_controls();
        jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        jump_target = '0; branch_target = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_req", imem_req, 0);
            check_eq("rst_pc", pc, 0);
            check_eq("rst_valid", instr_valid, 0);
            check_eq("rst_halted", halted, 0);
            check_eq("rst_addr_err", addr_err, 0);
        end
        rst = 1'b1;
        imem_ack = 1'b0;
        clear_controls();
        m_pc = '0;
        m_err = 1'b0;
        exp_q.delete();
        check_eq("boot_req", imem_req, 0);
        @(negedge clk);
        check_eq("boot_len_req", imem_req, 1);
        check_eq("boot_addr", imem_addr, 0);
    endtask

    // One instruction: ws wait states in FETCH, then EXEC with the given controls.
    task automatic do_instr(input int ws, input logic j, input logic [31:0] jt,
                            input logic b, input logic [31:0] bt, input logic h);
        int n = 0;
        logic [31:0] tgt;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("fetch_req", imem_req, 1);
        exp_q.push_back(m_pc);
        check_eq("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < ws; i++) begin
            imem_ack = 1'b0;
            junk_controls();
            @(negedge clk);
            check_eq("wait_req", imem_req, 1);
            check_eq("wait_addr", imem_addr, m_pc);
            check_eq("wait_valid", instr_valid, 0);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'($urandom);
        check_eq("exec_valid", instr_valid, 1);
        check_eq("exec_req", imem_req, 0);
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
        end else begin
            check_eq("exec_pc", pc, exp_q.pop_front());
        end
        check_eq("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt; halt = h;
        if (!h) begin
            if (j || b) begin
                tgt = j ? jt : bt;
`ifdef PC_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) begin
                    tgt = 32'h0000_0180;
                    m_err = 1'b1;
                end
`endif
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        imem_ack = 1'b0;
        clear_controls();
        check_eq("post_valid", instr_valid, 0);
        check_eq("post_halted", halted, h);
        check_eq("post_req", imem_req, !h);
        check_eq("post_pc", pc, m_pc);
        check_eq("post_addr_err", addr_err, m_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Sequential, zero-wait: 0,4,8,C
        for (int k = 0; k < 4; k++) do_instr(0, 0, '0, 0, '0, 0);
        // Wait states with ignored junk on controls
        do_instr(3, 0, '0, 0, '0, 0);
        // Priority: jump wins over branch, then branch alone
        do_instr(0, 1, 32'h40, 1, 32'h80, 0);
        do_instr(1, 0, '0, 1, 32'h80, 0);
        // Wrap at top of address space
        do_instr(0, 1, 32'hFFFF_FFFC, 0, '0, 0);
        do_instr(2, 0, '0, 0, '0, 0);
        check_eq("wrap_pc", pc, 32'h0);
        // Halt wins over jump
        do_instr(0, 1, 32'h40, 1, 32'h80, 1);
        repeat (10) begin
            imem_ack = 1'b1;
            junk_controls();
            @(negedge clk);
            check_eq("halt_req", imem_req, 0);
            check_eq("halt_halted", halted, 1);
            check_eq("halt_pc", pc, m_pc);
            check_eq("halt_valid", instr_valid, 0);
        end
        imem_ack = 1'b0;
        clear_controls();

        // Reset mid-fetch at 0x20
        apply_reset();
        do_instr(0, 1, 32'h20, 0, '0, 0);
        check_eq("mid_req", imem_req, 1);
        check_eq("mid_addr", imem_addr, 32'h20);
        @(posedge clk);
        #2;
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        check_eq("async_req", imem_req, 0);
        check_eq("async_pc", pc, 0);
        @(negedge clk);
        check_eq("rst_ack_req", imem_req, 0);
        check_eq("rst_ack_valid", instr_valid, 0);
        apply_reset();
        do_instr(0, 0, '0, 0, '0, 0);

        // Misaligned targets
        do_instr(0, 1, 32'h42, 0, '0, 0);
        do_instr(1, 0, '0, 0, '0, 0);
        do_instr(0, 0, '0, 1, 32'h81, 0);
        do_instr(0, 1, 32'h100, 0, '0, 0);
        do_instr(0, 0, '0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
